// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for a WIDTH-bit adder: sweeps every {A,B} operand pair,
// compares sum/carry/overflow against a golden model, counts mismatches and latches the first one.
module adder_bist_checker #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_carryout,
    input  logic                 dut_overflow,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 first_fail_valid,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_settle_cnt;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic                   r_ff_valid;
    logic [WIDTH-1:0]       r_ff_a;
    logic [WIDTH-1:0]       r_ff_b;
    logic [WIDTH+1:0]       w_golden;
    logic                   w_mismatch;
    logic                   w_vec_last;
    logic                   w_launch;

    // Returns {overflow, carry, sum} for carry-in = 0.
    function automatic logic [WIDTH+1:0] golden_add(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        logic           ov;
        sum = {1'b0, a} + {1'b0, b};
        ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        return {ov, sum};
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

    assign w_golden   = golden_add(r_a, r_b);
    assign w_mismatch = ({dut_overflow, dut_carryout, dut_sum} != w_golden);
    assign w_vec_last = &{r_a, r_b};
    assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next_state = S_SETTLE;
            S_SETTLE:       if (r_settle_cnt == '0) w_next_state = S_CHECK;
            S_CHECK:        w_next_state = w_vec_last ? S_DONE : S_SETTLE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_settle_cnt <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_err_cnt    <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
        end else if (w_launch) begin
            r_settle_cnt <= SETTLE_LOAD;
            r_a          <= '0;
            r_b          <= '0;
            r_err_cnt    <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
        end else if (r_state == S_SETTLE) begin
            if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - CNT_W'(1);
        end else if (r_state == S_CHECK) begin
            if (w_mismatch) begin
                r_err_cnt <= sat_inc(r_err_cnt);
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_a     <= r_a;
                    r_ff_b     <= r_b;
                end
            end
            // Last vector leaves operands parked at all-ones instead of wrapping.
            if (!w_vec_last) {r_a, r_b} <= {r_a, r_b} + (2*WIDTH)'(1);
            r_settle_cnt <= SETTLE_LOAD;
        end
    end

    assign a_out            = r_a;
    assign b_out            = r_b;
    assign busy             = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign done             = (r_state == S_DONE);
    assign pass             = done && (r_err_cnt == '0);
    assign err_count        = r_err_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_a     = r_ff_a;
    assign first_fail_b     = r_ff_b;

endmodule
